// File: rtl/bpf_defs.sv
// bpf_defs: shared ALU select codes, jump conditions, controller states and select legality
package bpf_defs;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_MUL = 4'h2, ALU_DIV = 4'h3,
    ALU_OR  = 4'h4, ALU_AND = 4'h5, ALU_LSH = 4'h6, ALU_RSH = 4'h7,
    ALU_NEG = 4'h8, ALU_MOD = 4'h9, ALU_XOR = 4'hA
  } alu_sel_e;
  typedef enum logic [1:0] {COND_EQ = 2'd0, COND_GT = 2'd1, COND_GE = 2'd2, COND_SET = 2'd3} cond_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RETIRE} state_t;
  function automatic logic sel_unsupported(input logic [3:0] sel);
    return sel inside {ALU_MUL, ALU_DIV, ALU_MOD} || sel > ALU_XOR;
  endfunction
endpackage

// File: rtl/jmp_target.sv
// jmp_target: resolved branch target pc + 1 + (taken ? jt : jf), wrapping at PC_WIDTH
module jmp_target #(
  parameter int PC_WIDTH = 10
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                taken,
  input  logic [7:0]          jt,
  input  logic [7:0]          jf,
  output logic [PC_WIDTH-1:0] target
);
  assign target = pc + PC_WIDTH'(1) + PC_WIDTH'(taken ? jt : jf);
endmodule

// File: rtl/alu_ctl.sv
// alu_ctl: issues one decoded ALU/jump op to the ALU, waits for its result and retires it
module alu_ctl
  import bpf_defs::*;
#(
  parameter int PC_WIDTH = 10,
  parameter int TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic                req_jmp,
  input  logic [3:0]          req_sel,
  input  logic [1:0]          req_cond,
  input  logic [31:0]         req_a,
  input  logic [31:0]         req_b,
  input  logic [PC_WIDTH-1:0] req_pc,
  input  logic [7:0]          req_jt,
  input  logic [7:0]          req_jf,
  output logic [31:0]         ALU_A,
  output logic [31:0]         ALU_B,
  output logic [3:0]          ALU_sel,
  output logic                ALU_en,
  input  logic [31:0]         ALU_out,
  input  logic                eq,
  input  logic                gt,
  input  logic                ge,
  input  logic                set,
  input  logic                ALU_vld,
  output logic                ALU_ack,
  output logic                acc_we,
  output logic [31:0]         acc_wdata,
  output logic                br_vld,
  output logic [PC_WIDTH-1:0] br_pc,
  output logic                done,
  output logic                err
);
  state_t              state_q, state_d;
  logic                jmp_q, jmp_d;
  logic [1:0]          cond_q, cond_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          jt_q, jt_d, jf_q, jf_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                acc_we_q, acc_we_d, br_vld_q, br_vld_d, err_q, err_d;
  logic [31:0]         acc_wdata_q, acc_wdata_d;
  logic [PC_WIDTH-1:0] br_pc_q, br_pc_d;
  logic                accept, taken, hit, timeout, finish;
  logic [PC_WIDTH-1:0] target;

  jmp_target #(.PC_WIDTH(PC_WIDTH)) u_jmp_target (
    .pc(pc_q), .taken(taken), .jt(jt_q), .jf(jf_q), .target(target)
  );

  assign req_rdy   = state_q == ST_IDLE || state_q == ST_RETIRE;
  assign ALU_en    = state_q == ST_ISSUE;
  assign done      = state_q == ST_RETIRE;
  assign ALU_ack   = state_q == ST_WAIT && ALU_vld && !rst;
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_sel   = sel_q;
  assign acc_we    = acc_we_q;
  assign acc_wdata = acc_wdata_q;
  assign br_vld    = br_vld_q;
  assign br_pc     = br_pc_q;
  assign err       = err_q;

  always_comb begin
    accept      = req_rdy && req_vld;
    taken       = cond_q == COND_EQ ? eq : cond_q == COND_GT ? gt : cond_q == COND_GE ? ge : set;
    hit         = state_q == ST_WAIT && ALU_vld;
    timeout     = TIMEOUT > 0 && state_q == ST_WAIT && !ALU_vld && cnt_q == 32'(TIMEOUT - 1);
    finish      = hit || timeout;
    state_d     = accept ? ST_ISSUE : state_q == ST_ISSUE ? ST_WAIT :
                  state_q == ST_WAIT ? (finish ? ST_RETIRE : ST_WAIT) : ST_IDLE;
    cnt_d       = state_q == ST_WAIT && !finish ? cnt_q + 32'd1 : '0;
    jmp_d       = accept ? req_jmp : jmp_q;
    cond_d      = accept ? req_cond : cond_q;
    sel_d       = accept ? (req_jmp ? 4'(ALU_ADD) : req_sel) : sel_q;
    a_d         = accept ? req_a : a_q;
    b_d         = accept ? req_b : b_q;
    pc_d        = accept ? req_pc : pc_q;
    jt_d        = accept ? req_jt : jt_q;
    jf_d        = accept ? req_jf : jf_q;
    acc_we_d    = hit && !jmp_q && !sel_unsupported(sel_q);
    br_vld_d    = hit && jmp_q;
    err_d       = finish ? (timeout || (!jmp_q && sel_unsupported(sel_q))) : err_q;
    acc_wdata_d = hit && !jmp_q ? ALU_out : acc_wdata_q;
    br_pc_d     = hit && jmp_q ? target : br_pc_q;
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      jmp_q       <= 1'b0;
      cond_q      <= '0;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pc_q        <= '0;
      jt_q        <= '0;
      jf_q        <= '0;
      acc_we_q    <= 1'b0;
      br_vld_q    <= 1'b0;
      err_q       <= 1'b0;
      acc_wdata_q <= '0;
      br_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      jmp_q       <= jmp_d;
      cond_q      <= cond_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pc_q        <= pc_d;
      jt_q        <= jt_d;
      jf_q        <= jf_d;
      acc_we_q    <= acc_we_d;
      br_vld_q    <= br_vld_d;
      err_q       <= err_d;
      acc_wdata_q <= acc_wdata_d;
      br_pc_q     <= br_pc_d;
    end
endmodule

// File: tb/tb_alu_ctl.sv
// tb_alu_ctl: randomized scoreboard bench for alu_ctl with a behavioural ALU responder
module tb_alu_ctl;
  localparam int PW = 10;
  localparam int TO = 4;

  logic clk = 0, rst = 1, req_vld = 0, req_jmp = 0;
  logic [3:0] req_sel = 0;
  logic [1:0] req_cond = 0;
  logic [31:0] req_a = 0, req_b = 0, alu_out = 0;
  logic [PW-1:0] req_pc = 0;
  logic [7:0] req_jt = 0, req_jf = 0;
  logic eq = 0, gt = 0, ge = 0, set = 0, alu_vld = 0;
  logic req_rdy, ALU_en, ALU_ack, acc_we, br_vld, done, err;
  logic [31:0] ALU_A, ALU_B, acc_wdata;
  logic [3:0] ALU_sel;
  logic [PW-1:0] br_pc;

  alu_ctl #(.PC_WIDTH(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_jmp(req_jmp),
    .req_sel(req_sel), .req_cond(req_cond), .req_a(req_a), .req_b(req_b), .req_pc(req_pc),
    .req_jt(req_jt), .req_jf(req_jf), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_sel(ALU_sel),
    .ALU_en(ALU_en), .ALU_out(alu_out), .eq(eq), .gt(gt), .ge(ge), .set(set),
    .ALU_vld(alu_vld), .ALU_ack(ALU_ack), .acc_we(acc_we), .acc_wdata(acc_wdata),
    .br_vld(br_vld), .br_pc(br_pc), .done(done), .err(err)
  );

  typedef struct {int cyc; bit acc_we; bit br_vld; bit err; bit chk_w; bit chk_pc; logic [31:0] wdata; logic [PW-1:0] pc;} exp_t;
  typedef struct {int cyc; int d; logic [3:0] sel; logic [31:0] a; logic [31:0] b;} iss_t;
  exp_t sb[$];
  iss_t iq[$];
  int tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference ALU behaviour; DIV yields a recognisable marker
  function automatic logic [31:0] alu_fn(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return 32'hDEADBEEF;
      4'd4: return a | b;
      4'd5: return a & b;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return -a;
      4'd10: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic [3:0] flags(input logic [31:0] a, input logic [31:0] b);
    return {(a & b) != 0, a >= b, a > b, a == b};
  endfunction

  function automatic bit unsup(input int s);
    int bad[8] = '{2, 3, 9, 11, 12, 13, 14, 15};
    foreach (bad[i]) if (bad[i] == s) return 1;
    return 0;
  endfunction

  // d >= 0: ALU answers d cycles late; -1: never answers (timeout); -2: reset test, stray valid later
  task automatic issue(input bit jmp, input logic [3:0] sel, input logic [1:0] cond, input logic [31:0] a,
                       input logic [31:0] b, input int pc, input int jt, input int jf, input int d);
    exp_t e;
    iss_t s;
    int n = 0;
    logic [3:0] f;
    req_vld = 1; req_jmp = jmp; req_sel = sel; req_cond = cond; req_a = a; req_b = b;
    req_pc = PW'(pc); req_jt = 8'(jt); req_jf = 8'(jf);
    while (!req_rdy && n < 20) begin @(negedge clk); n++; end
    chk("req_rdy_accept", {31'd0, req_rdy}, 1);
    if (!req_rdy) begin req_vld = 0; return; end
    s.cyc = cyc + 1; s.d = d; s.sel = jmp ? 4'd0 : sel; s.a = a; s.b = b;
    iq.push_back(s);
    if (d != -2) begin
      f = flags(a, b);
      e.cyc = cyc + (d < 0 ? 2 + TO : 3 + d);
      e.err = d < 0 || (!jmp && unsup(int'(sel)));
      e.acc_we = d >= 0 && !jmp && !unsup(int'(sel));
      e.br_vld = d >= 0 && jmp;
      e.chk_w = d >= 0 && !jmp;
      e.wdata = alu_fn(sel, a, b);
      e.chk_pc = d >= 0 && jmp;
      e.pc = PW'((pc + 1 + (f[cond] ? jt : jf)) % (1 << PW));
      sb.push_back(e);
    end
    @(negedge clk);
    req_vld = 0;
  endtask

  // ALU responder
  initial begin
    iss_t s;
    forever begin
      @(negedge clk);
      if (ALU_en) begin
        if (iq.size() == 0) chk("alu_en_unexpected", {31'd0, ALU_en}, 0);
        else begin
          s = iq.pop_front();
          chk("alu_en_cycle", cyc, s.cyc);
          chk("alu_sel", {28'd0, ALU_sel}, {28'd0, s.sel});
          chk("alu_a", ALU_A, s.a);
          chk("alu_b", ALU_B, s.b);
          if (s.d >= 0) begin
            @(posedge clk);
            repeat (s.d) @(posedge clk);
            #1;
            alu_out = alu_fn(ALU_sel, ALU_A, ALU_B);
            {set, ge, gt, eq} = flags(ALU_A, ALU_B);
            alu_vld = 1;
            @(negedge clk);
            chk("alu_ack", {31'd0, ALU_ack}, 1);
            @(posedge clk);
            #1 alu_vld = 0;
          end else if (s.d == -2) begin
            repeat (4) @(negedge clk);
            alu_out = 32'h12345678;
            alu_vld = 1;
            repeat (3) begin
              #1 chk("ack_after_rst", {31'd0, ALU_ack}, 0);
              @(negedge clk);
            end
            alu_vld = 0;
          end
        end
      end
    end
  end

  // Retire monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (ALU_ack && !alu_vld) chk("ack_without_vld", {31'd0, ALU_ack}, 0);
      if (done) begin
        if (sb.size() == 0) chk("done_unexpected", {31'd0, done}, 0);
        else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("acc_we", {31'd0, acc_we}, {31'd0, e.acc_we});
          chk("br_vld", {31'd0, br_vld}, {31'd0, e.br_vld});
          chk("err", {31'd0, err}, {31'd0, e.err});
          if (e.chk_w) chk("acc_wdata", acc_wdata, e.wdata);
          if (e.chk_pc) chk("br_pc", {22'd0, br_pc}, {22'd0, e.pc});
        end
      end else if (acc_we || br_vld) chk("strobe_without_done", {30'd0, acc_we, br_vld}, 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r, d;
    bit j;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", {31'd0, req_rdy}, 1);
    chk("rst_alu_en", {31'd0, ALU_en}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_acc_we", {31'd0, acc_we}, 0);
    chk("rst_br_vld", {31'd0, br_vld}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_acc_wdata", acc_wdata, 0);
    chk("rst_br_pc", {22'd0, br_pc}, 0);
    chk("rst_alu_a", ALU_A, 0);
    rst = 0;
    @(negedge clk);
    issue(0, 4'd0, 2'd0, 32'd5, 32'd7, 0, 0, 0, 0);
    issue(1, 4'd0, 2'd2, 32'd3, 32'd3, 100, 4, 9, 0);
    issue(1, 4'd0, 2'd2, 32'd2, 32'd3, 100, 4, 9, 1);
    issue(1, 4'd0, 2'd0, 32'd1, 32'd2, 1020, 0, 10, 0);
    issue(0, 4'd3, 2'd0, 32'd9, 32'd3, 0, 0, 0, 3);
    issue(0, 4'd0, 2'd0, 32'd1, 32'd1, 0, 0, 0, -1);
    issue(0, 4'd1, 2'd0, 32'd8, 32'd1, 0, 0, 0, -2);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midop_rst_req_rdy", {31'd0, req_rdy}, 1);
    chk("midop_rst_done", {31'd0, done}, 0);
    chk("midop_rst_acc_wdata", acc_wdata, 0);
    chk("midop_rst_err", {31'd0, err}, 0);
    rst = 0;
    repeat (6) @(negedge clk);
    repeat (150) begin
      r = $urandom_range(0, 9);
      j = $urandom_range(0, 2) == 0;
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? a : $urandom;
      d = r == 0 ? -1 : $urandom_range(0, 3);
      issue(j, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), a, b,
            $urandom_range(0, 1023), $urandom_range(0, 255), $urandom_range(0, 255), d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("issue_queue_drained", iq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_ctl.md
# alu_ctl

Issue/retire controller that drives the BPF CPU ALU and consumes its results. It accepts one decoded ALU or conditional-jump operation from the decode stage and presents operands, select and enable to the ALU. It waits for the ALU's valid and returns the acknowledge. It then retires the operation as an accumulator write-back or a resolved branch target for the PC stage.

## Interface
Parameters:
- `PC_WIDTH`, 10 — program counter width.
- `TIMEOUT`, 0 — maximum WAIT cycles before an error retire; 0 disables the timeout.

Ports:
- `clk` in 1 — the only clock.
- `rst` in 1 — synchronous, active-high reset.
- `req_vld` in 1 — decode presents an operation.
- `req_rdy` out 1 — controller can accept an operation.
- `req_jmp` in 1 — 1 = conditional jump, 0 = ALU op.
- `req_sel` in 4 — ALU select code.
- `req_cond` in 2 — jump predicate: 0 = eq, 1 = gt, 2 = ge, 3 = set.
- `req_a`, `req_b` in 32 — operands (accumulator; X or immediate).
- `req_pc` in PC_WIDTH — PC of the operation.
- `req_jt`, `req_jf` in 8 — jump offsets.
- `ALU_A`, `ALU_B` out 32 — operands to the ALU.
- `ALU_sel` out 4 — select to the ALU.
- `ALU_en` out 1 — ALU enable.
- `ALU_out` in 32 — ALU result.
- `eq`, `gt`, `ge`, `set` in 1 — ALU predicate flags.
- `ALU_vld` in 1 — ALU result valid.
- `ALU_ack` out 1 — acknowledge to the ALU.
- `acc_we` out 1 — accumulator write strobe.
- `acc_wdata` out 32 — accumulator write data.
- `br_vld` out 1 — branch-resolved strobe.
- `br_pc` out PC_WIDTH — resolved branch target.
- `done` out 1 — one pulse per retired operation.
- `err` out 1 — error flag, valid with `done`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RETIRE.
  - IDLE: `req_rdy`=1. On `req_vld`, register `req_*` and go to ISSUE.
  - ISSUE: `ALU_en`=1 for exactly one cycle, then go to WAIT.
  - WAIT: `ALU_ack`=1 combinationally in any cycle where `ALU_vld`=1. In that cycle, capture `ALU_out` and the selected flag, then go to RETIRE.
  - RETIRE: `done`=1 for one cycle, plus `acc_we` or `br_vld` as below. Go to IDLE.
- `ALU_A`, `ALU_B` and `ALU_sel` come from the operation registers. They are held stable from ISSUE until the next accept.
- ALU op retire: `acc_wdata` = captured `ALU_out`.
  - Sel 2, 3, 9 and 0xB–0xF are unsupported: `acc_we`=0, `err`=1.
  - All other sels: `acc_we`=1, `err`=0.
- Jump retire: taken = the flag chosen by `cond`.
  - `br_pc` = `pc` + 1 + zero-extended (taken ? `jt` : `jf`), modulo 2^PC_WIDTH (wraps).
  - `br_vld`=1, `acc_we`=0. `ALU_sel` is forced to 0 (add) for jumps; the result is ignored.
- Timeout: when `TIMEOUT`>0, a WAIT counter starts at 0. If it reaches `TIMEOUT` with no `ALU_vld`, go to RETIRE with `err`=1, no `acc_we`, no `br_vld`, and `ALU_ack` not driven.
- `ALU_vld` outside WAIT is ignored. `ALU_ack` is never asserted outside WAIT.
- Reset, including mid-operation, returns the FSM to IDLE. All outputs reset to 0 except `req_rdy`=1. The counter and operation registers clear; a pending ALU result is dropped.

## Timing
- Accept at cycle 0 (`req_vld` & `req_rdy`).
- `ALU_en`=1 in cycle 1. `ALU_vld` is first seen in cycle 2, where `ALU_ack`=1.
- `done`, `acc_we` and `br_vld` pulse in cycle 3.
- `req_rdy`=1 again in cycle 3; the next accept is in cycle 3 at the earliest. Throughput is one op per 3 cycles.
- Retire strobes are registered and last exactly one cycle. `acc_wdata`, `br_pc` and `err` hold until the next retire.
- Every `ALU_vld` is acked exactly once, so the ALU's valid clears on the following edge.

## Structure
- Shared package (`bpf_defs`):
  - ALU select constants (ADD … XOR).
  - Jump condition codes.
  - Unsupported-select predicate.
  - FSM state encoding.
- One sub-module, `jmp_target`: combinational PC + 1 + offset adder with taken mux, parameterised on PC_WIDTH.

## Test plan
- ALU add, A=5, B=7, sel 0 → `ALU_en` in cycle 1, `ALU_ack` in cycle 2, `acc_we`=1 with `acc_wdata`=12 in cycle 3, `err`=0.
- Jump ge, A=3, B=3, pc=100, jt=4, jf=9 → `br_vld`=1, `br_pc`=105. With A=2 → `br_pc`=110.
- Wrap: PC_WIDTH=10, pc=1020, jf=10, not taken → `br_pc`=7.
- Unsupported sel 3 (div) → `done`=1, `err`=1, `acc_we`=0, `acc_wdata`=0xDEADBEEF.
- TIMEOUT=4 with ALU valid held low → `done`+`err` after 4 WAIT cycles, `ALU_ack` never high.
- `rst` asserted in WAIT → next cycle IDLE, `req_rdy`=1, no retire strobe. A later `ALU_vld` produces no ack.
